// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler CPU peripherals.
//   nibble_t       : 4-bit datum carried on the CPU data bus
//   OUT_FIFO_DEPTH : default queue depth of the output port
package nibbler_pkg;

  typedef logic [3:0] nibble_t;

  localparam int OUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/out_port_if.sv
// Consumer-side ready/valid stream of the output port.
//   out_data  : FIFO head nibble, meaningful while out_valid = 1
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts out_data at this edge
// master = out_port (producer), slave = display driver / host link.
interface out_port_if;

  nibbler_pkg::nibble_t out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/nibble_fifo.sv
// First-word-fall-through nibble queue.
//   clock, reset : system clock, synchronous active-low reset
//   push_i/din_i : write request and its data
//   pop_req_i    : consumer ready; ignored while empty
//   dout_o       : registered head entry (holds last popped value when empty)
//   valid_o      : queue non-empty
//   count_o      : occupancy 0..DEPTH
//   drop_o       : push rejected this cycle because the queue is full and not popping
module nibble_fifo
  import nibbler_pkg::*;
#(
  parameter  int DEPTH = OUT_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  nibble_t       din_i,
  input  logic          pop_req_i,
  output nibble_t       dout_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  nibble_t       mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  nibble_t       head_q, head_d;

  logic empty, full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_req_i && !empty;
  // A pop at full frees the slot the push lands in, so both are accepted.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && full && !pop_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head_d   = head_q;
    // Pre-compute the head seen after this edge. The new head is the incoming
    // nibble only when it lands at the new read pointer (queue was empty, or
    // its single entry is popping); otherwise it is already in storage.
    if (count_d != '0) begin
      head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? din_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy and the head register guard every read.
  always_ff @(posedge clock) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = !empty;
  assign count_o = count_q;

endmodule

// File: rtl/out_port.sv
// Output port of the Nibbler CPU.
//   clock, reset : system clock, synchronous active-low reset
//   data_bus     : shared CPU data bus, sampled only while load_port = 1
//   load_port    : CPU output strobe, one write per high cycle
//   leds         : last nibble written, held until the next write
//   cons         : ready/valid stream of queued nibbles (master side)
//   overflow     : sticky, a write was dropped because the queue was full
//   clear_ovf    : clears overflow (a simultaneous drop wins)
//   count        : queue occupancy
// The block only listens to the data bus; it never drives it.
module out_port
  import nibbler_pkg::*;
#(
  parameter  int DEPTH = OUT_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  nibble_t       data_bus,
  input  logic          load_port,
  output nibble_t       leds,
  out_port_if.master    cons,
  output logic          overflow,
  input  logic          clear_ovf,
  output logic [CW-1:0] count
);

  nibble_t leds_q, leds_d;
  logic    ovf_q, ovf_d;
  logic    drop;
  nibble_t head;
  logic    head_valid;

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (load_port),
    .din_i     (data_bus),
    .pop_req_i (cons.out_ready),
    .dout_o    (head),
    .valid_o   (head_valid),
    .count_o   (count),
    .drop_o    (drop)
  );

  always_comb begin
    // The LED register takes every write, even ones the queue drops.
    leds_d = load_port ? data_bus : leds_q;
    // Set beats clear when both happen at the same edge.
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      leds_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      ovf_q  <= ovf_d;
    end
  end

  assign leds           = leds_q;
  assign overflow       = ovf_q;
  assign cons.out_data  = head;
  assign cons.out_valid = head_valid;

endmodule

// File: tb/tb_out_port.sv
// Directed bench for out_port: a vector table for the single-cycle behaviour,
// then hand-written sequences for backpressure and mid-stream reset.
module tb_out_port;
  import nibbler_pkg::*;

  logic       clock;
  logic       reset;
  nibble_t    data_bus;
  logic       load_port;
  nibble_t    leds;
  logic       overflow;
  logic       clear_ovf;
  logic [2:0] count;

  out_port_if u_if ();

  out_port dut (
    .clock     (clock),
    .reset     (reset),
    .data_bus  (data_bus),
    .load_port (load_port),
    .leds      (leds),
    .cons      (u_if),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       ld;
    nibble_t    d;
    logic       rdy;
    logic       clr;
    nibble_t    e_leds;
    logic       e_valid;
    nibble_t    e_data;
    logic [2:0] e_count;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t v(logic ld, nibble_t d, logic rdy, logic clr, nibble_t el,
                             logic ev, nibble_t ed, logic [2:0] ec, logic eo);
    vec_t r;
    r.ld = ld; r.d = d; r.rdy = rdy; r.clr = clr;
    r.e_leds = el; r.e_valid = ev; r.e_data = ed; r.e_count = ec; r.e_ovf = eo;
    return r;
  endfunction

  // Drive inputs, let one rising edge pass, and return 1 time unit after it.
  task automatic step(input logic ld, input nibble_t d, input logic rdy, input logic clr);
    load_port      = ld;
    data_bus       = d;
    u_if.out_ready = rdy;
    clear_ovf      = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int         wr, rd, cyc, pops;
    logic       hold, rdy;
    nibble_t    held;

    //        ld  data    rdy clr   leds   vld data  cnt ovf
    vecs[0]  = v(1, 4'hA,    0, 0,  4'hA, 1, 4'hA, 3'd1, 0); // single write
    vecs[1]  = v(0, 4'bxxxx, 1, 0,  4'hA, 0, 4'hA, 3'd0, 0); // pop, bus X ignored
    vecs[2]  = v(1, 4'h1,    0, 0,  4'h1, 1, 4'h1, 3'd1, 0); // fill
    vecs[3]  = v(1, 4'h2,    0, 0,  4'h2, 1, 4'h1, 3'd2, 0);
    vecs[4]  = v(1, 4'h3,    0, 0,  4'h3, 1, 4'h1, 3'd3, 0);
    vecs[5]  = v(1, 4'h4,    0, 0,  4'h4, 1, 4'h1, 3'd4, 0);
    vecs[6]  = v(1, 4'h5,    0, 0,  4'h5, 1, 4'h1, 3'd4, 1); // dropped, leds still 5
    vecs[7]  = v(0, 4'h0,    1, 0,  4'h5, 1, 4'h2, 3'd3, 1); // drain 1..4
    vecs[8]  = v(0, 4'h0,    1, 0,  4'h5, 1, 4'h3, 3'd2, 1);
    vecs[9]  = v(0, 4'h0,    1, 0,  4'h5, 1, 4'h4, 3'd1, 1);
    vecs[10] = v(0, 4'h0,    1, 0,  4'h5, 0, 4'h4, 3'd0, 1);
    vecs[11] = v(0, 4'h0,    1, 1,  4'h5, 0, 4'h4, 3'd0, 0); // clear; ready while empty
    vecs[12] = v(1, 4'h1,    0, 0,  4'h1, 1, 4'h1, 3'd1, 0); // refill 1..4
    vecs[13] = v(1, 4'h2,    0, 0,  4'h2, 1, 4'h1, 3'd2, 0);
    vecs[14] = v(1, 4'h3,    0, 0,  4'h3, 1, 4'h1, 3'd3, 0);
    vecs[15] = v(1, 4'h4,    0, 0,  4'h4, 1, 4'h1, 3'd4, 0);
    vecs[16] = v(1, 4'h6,    1, 0,  4'h6, 1, 4'h2, 3'd4, 0); // push+pop at full
    vecs[17] = v(1, 4'h7,    0, 1,  4'h7, 1, 4'h2, 3'd4, 1); // drop beats clear
    vecs[18] = v(0, 4'h0,    1, 0,  4'h7, 1, 4'h3, 3'd3, 1); // drain 2,3,4,6
    vecs[19] = v(0, 4'h0,    1, 1,  4'h7, 1, 4'h4, 3'd2, 0);
    vecs[20] = v(0, 4'h0,    1, 0,  4'h7, 1, 4'h6, 3'd1, 0);
    vecs[21] = v(0, 4'h0,    1, 0,  4'h7, 0, 4'h6, 3'd0, 0);
    vecs[22] = v(1, 4'h8,    0, 0,  4'h8, 1, 4'h8, 3'd1, 0); // push+pop with one entry
    vecs[23] = v(1, 4'h9,    1, 0,  4'h9, 1, 4'h9, 3'd1, 0);
    vecs[24] = v(1, 4'hB,    1, 0,  4'hB, 1, 4'hB, 3'd1, 0);
    vecs[25] = v(0, 4'bxxxx, 1, 0,  4'hB, 0, 4'hB, 3'd0, 0);

    // Reset with write strobe active: reset must win.
    reset = 1'b0;
    step(1'b1, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b0);
    check("reset leds",  8'(leds), 8'h0);
    check("reset valid", 8'(u_if.out_valid), 8'h0);
    check("reset data",  8'(u_if.out_data), 8'h0);
    check("reset count", 8'(count), 8'h0);
    check("reset ovf",   8'(overflow), 8'h0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].ld, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      check($sformatf("v%0d leds", i),  8'(leds),            8'(vecs[i].e_leds));
      check($sformatf("v%0d valid", i), 8'(u_if.out_valid),  8'(vecs[i].e_valid));
      check($sformatf("v%0d data", i),  8'(u_if.out_data),   8'(vecs[i].e_data));
      check($sformatf("v%0d count", i), 8'(count),           8'(vecs[i].e_count));
      check($sformatf("v%0d ovf", i),   8'(overflow),        8'(vecs[i].e_ovf));
    end

    // Backpressure: writer paced by occupancy, consumer ready is random.
    wr = 0; rd = 0; cyc = 0; hold = 1'b0; held = '0;
    while (rd < 16 && cyc < 400) begin
      if (hold) begin
        check("bp valid held", 8'(u_if.out_valid), 8'h1);
        check("bp data stable", 8'(u_if.out_data), 8'(held));
      end
      rdy = 1'($urandom_range(0, 1));
      if (u_if.out_valid && rdy) begin
        check($sformatf("bp order %0d", rd), 8'(u_if.out_data), 8'(rd));
        rd++;
      end
      hold = u_if.out_valid && !rdy;
      held = u_if.out_data;
      if (wr < 16 && count < 3'd4) begin
        step(1'b1, nibble_t'(wr), rdy, 1'b0);
        wr++;
      end else begin
        step(1'b0, 4'bxxxx, rdy, 1'b0);
      end
      cyc++;
    end
    check("bp all received", 8'(rd), 8'd16);
    check("bp empty after", 8'(count), 8'h0);
    check("bp no overflow", 8'(overflow), 8'h0);

    // Mid-stream reset: three queued entries are discarded.
    step(1'b1, 4'hC, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    check("pre-reset count", 8'(count), 8'h3);
    reset = 1'b0;
    step(1'b1, 4'hF, 1'b1, 1'b0);
    check("mid reset leds",  8'(leds), 8'h0);
    check("mid reset valid", 8'(u_if.out_valid), 8'h0);
    check("mid reset data",  8'(u_if.out_data), 8'h0);
    check("mid reset count", 8'(count), 8'h0);
    check("mid reset ovf",   8'(overflow), 8'h0);
    reset = 1'b1;
    step(1'b1, 4'h9, 1'b1, 1'b0);
    check("post reset leds",  8'(leds), 8'h9);
    check("post reset count", 8'(count), 8'h1);
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      if (u_if.out_valid) begin
        check("post reset data", 8'(u_if.out_data), 8'h9);
        pops++;
      end
      step(1'b0, 4'bxxxx, 1'b1, 1'b0);
    end
    check("post reset pops", 8'(pops), 8'h1);
    check("post reset empty", 8'(count), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
